// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Every op, including divide-by-zero, takes 33 cycles from start to valid hi/lo.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state  | meaning
    // S_IDLE | waiting for start, busy=0
    // S_CALC | WIDTH shift-add / shift-subtract iterations
    // S_FIX  | sign correction, hi/lo write, done pulse
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              div0_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;

    logic              neg_a;
    logic              neg_b;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  a_d;
    logic [WIDTH-1:0]  hi_d;
    logic [WIDTH-1:0]  lo_d;

    assign neg_a = A[WIDTH-1] & ~op[0];
    assign neg_b = B[WIDTH-1] & ~op[0];

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, a_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        acc_d     = acc_q;
        a_d       = a_q;
        if (is_div_q) begin
            // Borrow out of the WIDTH+1-bit subtract means the divisor did not fit.
            if (!div_diff[WIDTH]) begin
                acc_d = div_diff[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_q, a_q};
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            // With B=0 the remainder chain just shifts |A| through, so hi=A falls out.
            hi_d = sign_a_q ? -acc_q : acc_q;
            if (div0_q) begin
                lo_d = '1;
            end else begin
                lo_d = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        div0_q   <= (B == '0);
                        a_q      <= neg_a ? -A : A;
                        b_q      <= neg_b ? -B : B;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: reference results queued at start, checked when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: model = sa * sb;
            2'd1: model = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = {32'b0, a} / {32'b0, b};
                        r = {32'b0, a} % {32'b0, b};
                    end
                    model = {r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    // Called at a negedge; raises start for one edge and returns at the following negedge.
    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_accept);
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        if (expect_accept) exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
        op = $urandom_range(0, 3);
        A = $urandom;
        B = $urandom;
    endtask

    // Waits (bounded) for done; reports cycles since E0, busy cycles, and whether hi/lo held.
    task automatic run_to_done(input int n0, output int n, output int busy_n, output bit hold_ok);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = hi;
        lo0 = lo;
        n = n0;
        busy_n = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && n < 80) begin
            if (busy === 1'b1) busy_n++;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op = 2'd0;
        A = 32'd0;
        B = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu;
        int n;
        int bn;
        bit hold;
        logic [63:0] e;
        drive_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_to_done(0, n, bn, hold);
        checks++; if (n != 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", n); end
        checks++; if (bn != 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bn); end
        checks++; if (!hold) begin failures++; $display("FAIL multu_hold got=changed exp=held"); end
        e = exp_q.pop_front();
        checks++; if (hi !== 32'hFFFF_FFFE || hi !== e[63:32]) begin failures++; $display("FAIL multu_hi got=%h exp=%h", hi, e[63:32]); end
        checks++; if (lo !== 32'h0000_0001 || lo !== e[31:0]) begin failures++; $display("FAIL multu_lo got=%h exp=%h", lo, e[31:0]); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_idle_busy got=%b exp=0", busy); end
    endtask

    // Table-driven ops covering signed multiply and the divide sign/boundary cases.
    task automatic run_table(input string tag, input logic [1:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
        int n;
        int bn;
        bit hold;
        logic [63:0] e;
        foreach (ops[i]) begin
            drive_start(ops[i], as[i], bs[i], 1'b1);
            run_to_done(0, n, bn, hold);
            e = exp_q.pop_front();
            checks++; if (n != 33) begin failures++; $display("FAIL %s[%0d]_latency got=%0d exp=33", tag, i, n); end
            checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL %s[%0d]_hi got=%h exp=%h", tag, i, hi, e[63:32]); end
            checks++; if (lo !== e[31:0]) begin failures++; $display("FAIL %s[%0d]_lo got=%h exp=%h", tag, i, lo, e[31:0]); end
            @(negedge clk);
        end
    endtask

    task automatic test_mult_div;
        int n;
        int bn;
        bit hold;
        logic [63:0] e;
        drive_start(2'd0, 32'hFFFF_E890, 32'd5000, 1'b1);
        run_to_done(0, n, bn, hold);
        e = exp_q.pop_front();
        checks++; if (hi !== 32'hFFFF_FFFF || hi !== e[63:32]) begin failures++; $display("FAIL mult_hi got=%h exp=%h", hi, e[63:32]); end
        checks++; if (lo !== 32'hFE36_3C80 || lo !== e[31:0]) begin failures++; $display("FAIL mult_lo got=%h exp=%h", lo, e[31:0]); end
        drive_start(2'd2, 32'd6000, 32'd5000, 1'b1);
        run_to_done(0, n, bn, hold);
        e = exp_q.pop_front();
        checks++; if (!hold) begin failures++; $display("FAIL div_hold got=changed exp=held"); end
        checks++; if (lo !== 32'd1 || lo !== e[31:0]) begin failures++; $display("FAIL div_lo got=%h exp=%h", lo, e[31:0]); end
        checks++; if (hi !== 32'd1000 || hi !== e[63:32]) begin failures++; $display("FAIL div_hi got=%h exp=%h", hi, e[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_div_signs;
        logic [1:0]  o[] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3};
        logic [31:0] a[] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] b[] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                             32'h8000_0000, 32'd3, 32'd9};
        run_table("div_signs", o, a, b);
    endtask

    task automatic test_div_by_zero;
        logic [1:0]  o[] = '{2'd3, 2'd2, 2'd2};
        logic [31:0] a[] = '{32'd1234, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] b[] = '{32'd0, 32'd0, 32'd0};
        int n;
        int bn;
        bit hold;
        drive_start(2'd3, 32'd1234, 32'd0, 1'b1);
        run_to_done(0, n, bn, hold);
        checks++; if (n != 33) begin failures++; $display("FAIL div0_latency got=%0d exp=33", n); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd1234) begin failures++; $display("FAIL div0_hi got=%h exp=000004d2", hi); end
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL div0_done_pulse got=%b exp=0", done); end
        run_table("div0", o, a, b);
    endtask

    task automatic test_ignored_start_and_back_to_back;
        int n;
        int bn;
        bit hold;
        logic [63:0] e;
        drive_start(2'd1, 32'd3, 32'd5, 1'b1);
        repeat (9) @(negedge clk);
        drive_start(2'd2, 32'd100, 32'd7, 1'b0);
        run_to_done(10, n, bn, hold);
        e = exp_q.pop_front();
        checks++; if (n != 33) begin failures++; $display("FAIL ignored_latency got=%0d exp=33", n); end
        checks++; if (hi !== 32'd0 || hi !== e[63:32]) begin failures++; $display("FAIL ignored_hi got=%h exp=%h", hi, e[63:32]); end
        checks++; if (lo !== 32'd15 || lo !== e[31:0]) begin failures++; $display("FAIL ignored_lo got=%h exp=%h", lo, e[31:0]); end
        drive_start(2'd3, 32'd100, 32'd7, 1'b1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", done); end
        run_to_done(0, n, bn, hold);
        e = exp_q.pop_front();
        checks++; if (n != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", n); end
        checks++; if (lo !== 32'd14 || lo !== e[31:0]) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", lo, e[31:0]); end
        checks++; if (hi !== 32'd2 || hi !== e[63:32]) begin failures++; $display("FAIL b2b_hi got=%h exp=%h", hi, e[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int dones;
        drive_start(2'd3, 32'd100, 32'd7, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_div_signs();
        test_div_by_zero();
        test_ignored_start_and_back_to_back();
        test_reset_midop();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath, consuming the same 32-bit operand pair A/B that feeds the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU iteratively and holds the 64-bit result in HI/LO registers.
- The controller issues a one-cycle start, polls busy, and reads hi/lo (MFHI/MFLO) after done.

Parameters:
- WIDTH, 32, operand width and HI/LO register width. Iteration count equals WIDTH.

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- reset  input  1  Asynchronous, active-high reset.
- start  input  1  Request pulse; sampled only while idle.
- op  input  2  Operation: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
- A  input  WIDTH  Multiplicand or dividend (rs).
- B  input  WIDTH  Multiplier or divisor (rt).
- busy  output  1  High while an operation is in flight.
- done  output  1  One-cycle pulse when hi/lo have just been updated.
- hi  output  WIDTH  Product upper half, or remainder.
- lo  output  WIDTH  Product lower half, or quotient.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-operation):
  - state returns to IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Iteration counter and working registers are cleared. The in-flight operation is discarded.
- States:
  - IDLE: busy=0.
  - CALC: WIDTH iterations, busy=1.
  - FIX: one cycle for sign correction, busy=1.
- Edge E0, IDLE with start=1:
  - Latch op and the signs of A and B.
  - Latch magnitudes: |A| and |B| for signed ops; raw values for unsigned ops.
  - Clear the counter and go to CALC.
  - busy=1 from E0 onward.
- Edges E1..E32, CALC:
  - Multiply: one shift-add step per edge (radix-2).
  - Divide: one restoring shift-subtract step per edge, using a WIDTH+1-bit partial remainder.
  - At E32 the counter reaches WIDTH-1 and the state moves to FIX.
- Edge E33, FIX:
  - Apply sign correction.
  - Write hi/lo, set done=1, busy=0, return to IDLE.
  - done is high exactly one cycle, after E33 until E34.
  - Fixed latency is 33 cycles from the start edge to valid hi/lo for every op, including divide-by-zero.
- Sign rules:
  - MULT: the 64-bit magnitude product is negated if sign(A) XOR sign(B).
  - DIV: the quotient is negated if sign(A) XOR sign(B), so it truncates toward zero.
  - DIV: the remainder takes the sign of the dividend.
- DIV of -2^31 by -1: yields lo=0x80000000, hi=0. This falls out of the magnitude algorithm with no trap.
- Divide by zero (DIV or DIVU with B=0):
  - lo=0xFFFFFFFF, hi=original A.
  - Same 33-cycle latency, no error flag.
- start while busy=1: ignored. Operands and op are not re-latched and the current operation is undisturbed.
- start in the cycle done=1: accepted, because state is IDLE. busy rises at that edge.
- A, B and op may change freely after E0. Only the E0 values are used.
- hi/lo hold their previous values throughout an operation and change only at the FIX edge (or on reset).

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=-6000 (0xFFFFE890), B=5000 -> hi=0xFFFFFFFF, lo=0xFE363C80; then DIV A=6000 B=5000 -> lo=1, hi=1000.
- DIV A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=0xFFFFFFF9 B=2 -> lo=0x7FFFFFFC, hi=1. DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=1234 B=0 -> after 33 cycles lo=0xFFFFFFFF, hi=1234, done pulses once.
- MULTU 3*5 started, then start asserted with op=DIV A=100 B=7 at cycle 10 -> ignored; result hi=0, lo=15. Back-to-back start in the done cycle with DIVU 100/7 -> lo=14, hi=2, 33 cycles later.
- Assert reset at cycle 20 of DIVU 100/7 -> immediately busy=0, done=0, hi=lo=0. After release, no done pulse occurs until a new start.
